instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder counterpart of the main control decoder: packs decoded instruction fields into
//  32-bit MIPS words and streams them into instruction memory at sequential addresses.
//  Sits between the test/boot program source and the imem write port; loads the program
//  the processor's decode path later consumes.
// PARAMETERS
//  ADDR_W     8    imem word-address width
//  BASE_ADDR  0    first word address written after each start
//  DEPTH      256  max words per load; must be <= 2**ADDR_W
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       begin a load (honoured in IDLE or DONE only)
//  in_valid     in   1       field beat valid
//  in_ready     out  1       beat accepted when in_valid & in_ready
//  in_opcode    in   6       opcode field [31:26]
//  in_rs/in_rt  in   5 each  register fields
//  in_rd        in   5       R-type destination
//  in_shamt     in   5       R-type shift amount
//  in_funct     in   6       R-type function
//  in_imm       in   16      I-type immediate/offset
//  in_last      in   1       marks final beat of program
//  imem_we      out  1       imem write strobe, one cycle per word
//  imem_addr    out  ADDR_W  write address
//  imem_wdata   out  32      encoded instruction
//  busy         out  1       state==LOAD
//  done         out  1       state==DONE
//  overflow     out  1       sticky: load stopped at DEPTH without in_last
//  word_count   out  ADDR_W+1  words written this load
//  err_illegal  out  1       sticky illegal-opcode flag (ILLEGAL_CHECK_EN only, else 0)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; addr ptr = BASE_ADDR. rst beats start/in_valid same cycle.
//  - FSM: IDLE -start-> LOAD; LOAD -accepted in_last or DEPTH-th word-> DONE; DONE -start-> LOAD.
//    start clears word_count, overflow, err_illegal, ptr=BASE_ADDR. start in LOAD ignored.
//  - in_ready = (state==LOAD), combinational from state only.
//  - Encoding: opcode 0x00 -> R {op,rs,rt,rd,shamt,funct};
//    0x08,0x23,0x2B,0x21,0x25,0x04 -> I {op,rs,rt,imm}.
//  - Latency 1: beat accepted in cycle N -> imem_we=1, imem_addr=ptr, imem_wdata valid in N+1;
//    ptr and word_count increment with that write. imem_we deasserts when no beat accepted.
//  - Wrap: ptr = (BASE_ADDR+word_count) mod 2**ADDR_W; wraps silently past max address.
//  - Full: DEPTH-th write without in_last -> DONE with overflow=1; further beats not accepted.
//  - in_last on the DEPTH-th beat -> DONE, overflow=0.
//  - Reset mid-LOAD: pending write dropped (imem_we=0 next cycle), back to IDLE.
// CONFIGURATION
//  ILLEGAL_CHECK_EN defined: opcode outside the supported set is accepted but not written
//   (no imem_we, no ptr/count advance) and sets err_illegal; in_last on it still ends load.
//  Undefined: any non-zero opcode encoded as I-type and written; err_illegal tied 0.
// STRUCTURE
//  - mips_isa_pkg: OP_RTYPE/OP_ADDI/OP_LW/OP_SW/OP_LH/OP_LHU/OP_BEQ constants,
//    field width localparams, loader_state_t enum {IDLE,LOAD,DONE}; shared with main control.
//  - Sub-module instr_field_packer: combinational fields->32-bit word plus legal flag;
//    top holds FSM, ptr, counters, output regs.
// TESTING
//  1 start; beat add $3,$1,$2 (op0 rs1 rt2 rd3 sh0 fn0x20, last)
//    -> next cycle we=1 addr=0 wdata=0x00221820; done=1, word_count=1.
//  2 beats addi $2,$1,5 / lw $4,8($5) / beq $1,$2,-1 (last), back-to-back
//    -> wdata 0x20220005, 0x8CA40008, 0x1022FFFF at addr 0,1,2 on consecutive cycles.
//  3 DEPTH=4, 5 beats no last -> 4 writes (addr 0..3), done=1, overflow=1, in_ready=0 after.
//  4 rst asserted the cycle a beat is accepted -> no imem_we next cycle, IDLE, outputs 0.
//  5 ILLEGAL_CHECK_EN, op 0x3F mid-stream -> err_illegal=1, no write, next legal beat takes
//    the skipped address; without macro -> written as {0x3F,rs,rt,imm}.
//  6 BASE_ADDR=254, ADDR_W=8, 3 beats -> addr 254,255,0; second start restarts at 254.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA field widths and opcodes, plus the loader FSM state type.
// Shared between the main control decoder and the instruction encoder/loader.
package mips_isa_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_LH    = 6'h21;
  localparam logic [OPCODE_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    unique case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_LH, OP_LHU, OP_BEQ: is_legal_op = 1'b1;
      default:                                                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded MIPS fields -> 32-bit instruction word plus legal flag.
// Opcode 0 packs R-type; any other opcode packs I-type.
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [REG_W-1:0]    i_rs,
  input  logic [REG_W-1:0]    i_rt,
  input  logic [REG_W-1:0]    i_rd,
  input  logic [SHAMT_W-1:0]  i_shamt,
  input  logic [FUNCT_W-1:0]  i_funct,
  input  logic [IMM_W-1:0]    i_imm,
  output logic [INSTR_W-1:0]  o_word,
  output logic                o_legal
);

  always_comb begin
    o_word  = '0;
    o_legal = is_legal_op(i_opcode);
    if (i_opcode == OP_RTYPE) begin
      o_word = {i_opcode, i_rs, i_rt, i_rd, i_shamt, i_funct};
    end else begin
      o_word = {i_opcode, i_rs, i_rt, i_imm};
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams packed MIPS instructions into imem at sequential (wrapping) addresses.
// Optional feature macro: ILLEGAL_CHECK_EN (drop unsupported opcodes, flag err_illegal).
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [OPCODE_W-1:0] i_in_opcode,
  input  logic [REG_W-1:0]    i_in_rs,
  input  logic [REG_W-1:0]    i_in_rt,
  input  logic [REG_W-1:0]    i_in_rd,
  input  logic [SHAMT_W-1:0]  i_in_shamt,
  input  logic [FUNCT_W-1:0]  i_in_funct,
  input  logic [IMM_W-1:0]    i_in_imm,
  input  logic                i_in_last,
  output logic                o_imem_we,
  output logic [ADDR_W-1:0]   o_imem_addr,
  output logic [INSTR_W-1:0]  o_imem_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [ADDR_W:0]     o_word_count,
  output logic                o_err_illegal
);

`ifdef ILLEGAL_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DepthM1  = (ADDR_W + 1)'(DEPTH - 1);

  loader_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0]    r_ptr, r_addr;
  logic [INSTR_W-1:0]   r_wdata;
  logic [ADDR_W:0]      r_count;
  logic                 r_we, r_overflow, r_err;
  logic [INSTR_W-1:0]   w_word;
  logic                 w_legal, w_accept, w_write, w_illegal, w_full, w_start_ok;

  instr_field_packer u_packer (
    .i_opcode (i_in_opcode),
    .i_rs     (i_in_rs),
    .i_rt     (i_in_rt),
    .i_rd     (i_in_rd),
    .i_shamt  (i_in_shamt),
    .i_funct  (i_in_funct),
    .i_imm    (i_in_imm),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  assign w_accept   = i_in_valid && (r_state == LOAD);
  // Without the check every accepted beat is written, whatever its opcode.
  assign w_write    = w_accept && (w_legal || !CheckEn);
  assign w_illegal  = CheckEn && w_accept && !w_legal;
  assign w_full     = w_write && (r_count == DepthM1);
  assign w_start_ok = i_start && (r_state != LOAD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    if ((w_accept && i_in_last) || w_full) w_state_next = DONE;
      DONE:    if (i_start) w_state_next = LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ptr      <= BaseAddr;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_start_ok) begin
        r_ptr      <= BaseAddr;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_err      <= 1'b0;
      end
      if (w_write) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_ptr   <= r_ptr + ADDR_W'(1);
        r_count <= r_count + (ADDR_W + 1)'(1);
        if (w_full && !i_in_last) r_overflow <= 1'b1;
      end
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign o_in_ready    = (r_state == LOAD);
  assign o_busy        = (r_state == LOAD);
  assign o_done        = (r_state == DONE);
  assign o_imem_we     = r_we;
  assign o_imem_addr   = r_addr;
  assign o_imem_wdata  = r_wdata;
  assign o_word_count  = r_count;
  assign o_overflow    = r_overflow;
  assign o_err_illegal = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (BASE_ADDR=254, DEPTH=4 to reach wrap and full).
// Expectations follow ILLEGAL_CHECK_EN the same way the design build does.
module tb_instr_encoder_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned BASE  = 254;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        in_ready, imem_we, busy, done, overflow, err_illegal;
  logic [AW-1:0]  imem_addr;
  logic [31:0]    imem_wdata;
  logic [AW:0]    word_count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_opcode(op), .i_in_rs(rs), .i_in_rt(rt), .i_in_rd(rd), .i_in_shamt(shamt),
    .i_in_funct(funct), .i_in_imm(imm), .i_in_last(in_last), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata), .o_busy(busy), .o_done(done),
    .o_overflow(overflow), .o_word_count(word_count), .o_err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ILLEGAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference model state: 0 idle, 1 load, 2 done.
  int m_state = 0;
  int m_count = 0;
  bit m_ovf   = 1'b0;
  bit m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(imem_we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("imem_addr", 32'(imem_addr), 32'(e.addr));
        check("imem_wdata", imem_wdata, e.wdata);
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    if (m_state != 1) begin
      m_state = 1; m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // wr: whether this beat should reach imem when accepted.
  task automatic beat(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] im, input logic last, input logic [31:0] exp_w,
                      input bit wr);
    op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; in_last = last;
    in_valid = 1'b1;
    if (m_state == 1) begin
      if (wr) begin
        sb.push_back('{addr: AW'((BASE + m_count) % (1 << AW)), wdata: exp_w});
        m_count++;
      end else begin
        m_err = 1'b1;
      end
      if (last) m_state = 2;
      else if (wr && m_count == DEPTH) begin
        m_state = 2; m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic settle_and_check(input string tag);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); #1;
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(m_state == 2));
    check({tag, "_busy"}, 32'(busy), 32'(m_state == 1));
    check({tag, "_word_count"}, 32'(word_count), 32'(m_count));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_err_illegal"}, 32'(err_illegal), 32'(m_err));
    @(posedge clk); #1;
    check({tag, "_we_idle"}, 32'(imem_we), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_count", 32'(word_count), 32'd0);

    // add $3,$1,$2 as a single-word program
    do_start();
    check("ready_in_load", 32'(in_ready), 32'd1);
    beat(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 1'b1, 32'h0022_1820, 1'b1);
    settle_and_check("t1");

    // back-to-back I-types, wrapping past address 255
    do_start();
    beat(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 1'b0, 32'h2022_0005, 1'b1);
    beat(6'h23, 5'd5, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0008, 1'b0, 32'h8CA4_0008, 1'b1);
    beat(6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 1'b1, 32'h1022_FFFF, 1'b1);
    settle_and_check("t2");

    // five beats without last: stops at DEPTH with overflow
    do_start();
    for (int i = 0; i < 5; i++) begin
      beat(6'h2B, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h0, 16'(i),
           1'b0, {6'h2B, 5'(i), 5'(i + 1), 16'(i)}, 1'b1);
    end
    settle_and_check("t3");
    check("t3_ready_after_full", 32'(in_ready), 32'd0);

    // unsupported opcode mid-stream; start during LOAD must be ignored
    do_start();
    beat(6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0010, 1'b0, 32'h2064_0010, 1'b1);
    start = 1'b1;
    beat(6'h3F, 5'd7, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1234, 1'b0, {6'h3F, 5'd7, 5'd8, 16'h1234},
         !CHK);
    start = 1'b0;
    beat(6'h25, 5'd9, 5'd10, 5'd0, 5'd0, 6'h0, 16'h00AA, 1'b1, 32'h952A_00AA, 1'b1);
    settle_and_check("t5");

    // reset on the cycle a beat is accepted drops the write
    do_start();
    op = 6'h08; rs = 5'd1; rt = 5'd1; imm = 16'h0001; in_last = 1'b0;
    in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    m_state = 0; m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
    check("t4_we", 32'(imem_we), 32'd0);
    check("t4_state", {29'd0, in_ready, busy, done}, 32'd0);
    check("t4_count", 32'(word_count), 32'd0);
    check("t4_addr_wdata", imem_wdata | 32'(imem_addr), 32'd0);
    check("t4_flags", {30'd0, overflow, err_illegal}, 32'd0);
    @(posedge clk); #1;
    check("t4_we_later", 32'(imem_we), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
